// File: rtl/semaforo_pkg.sv
// Shared encodings for the semaforo light monitor.
// Light states, error codes and the dwell counter type.
package semaforo_pkg;

    localparam logic [2:0] VERDE_S    = 3'b001;
    localparam logic [2:0] AMARELO_S  = 3'b010;
    localparam logic [2:0] VERMELHO_S = 3'b100;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ENC      = 3'd1,
        ERR_CONFLICT = 3'd2,
        ERR_SEQ      = 3'd3,
        ERR_DUR      = 3'd4
    } err_code_t;

    typedef logic [7:0] dwell_t;

    function automatic logic legal_step(input logic [2:0] prev,
                                        input logic [2:0] cur);
        logic ok;
        ok = 1'b0;
        unique case (prev)
            VERDE_S:    ok = (cur == AMARELO_S);
            AMARELO_S:  ok = (cur == VERMELHO_S);
            VERMELHO_S: ok = (cur == VERDE_S);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sem_phase_tracker.sv
// Per-light phase tracker: remembers the last valid state and its dwell,
// and flags encoding, sequence and (optionally) duration errors.
module sem_phase_tracker
    import semaforo_pkg::*;
#(
    parameter bit CHECK_DUR = 1'b1,
    parameter int T_G       = 1,
    parameter int T_Y       = 3,
    parameter int T_R       = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_st,
    output logic       o_enc_err,
    output logic       o_seq_err,
    output logic       o_dur_err,
    output logic       o_red_to_green,
    output logic       o_is_red
);

    logic [2:0] r_prev;
    logic       r_valid;
    dwell_t     r_dwell;

    logic       w_onehot;
    logic       w_same;
    dwell_t     w_dwell_nxt;
    logic [8:0] w_dw9;
    logic       w_over;
    logic       w_short_y;

    assign w_onehot = (i_st == VERDE_S) || (i_st == AMARELO_S) ||
                      (i_st == VERMELHO_S);
    assign w_same   = r_valid && (i_st == r_prev);

    assign w_dwell_nxt = !w_same ? 8'd1 :
                         (r_dwell == 8'hFF) ? r_dwell : r_dwell + 8'd1;
    assign w_dw9 = {1'b0, w_dwell_nxt};

    // Overstay fires at limit+1 and on every later sample of the same state.
    assign w_over = ((i_st == VERDE_S)    && (w_dw9 > 9'(T_G))) ||
                    ((i_st == AMARELO_S)  && (w_dw9 > 9'(T_Y))) ||
                    ((i_st == VERMELHO_S) && (w_dw9 > 9'(T_R)));
    assign w_short_y = r_valid && (r_prev == AMARELO_S) &&
                       (i_st == VERMELHO_S) && (r_dwell != 8'(T_Y));

    assign o_enc_err = !w_onehot;
    assign o_seq_err = w_onehot && r_valid && !w_same &&
                       !legal_step(r_prev, i_st);
    assign o_dur_err = CHECK_DUR && w_onehot && (w_over || w_short_y);
    assign o_red_to_green = r_valid && (r_prev == VERMELHO_S) &&
                            (i_st == VERDE_S);
    assign o_is_red = (i_st == VERMELHO_S);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= 3'd0;
            r_valid <= 1'b0;
            r_dwell <= 8'd0;
        end else if (!w_onehot) begin
            r_valid <= 1'b0;
            r_dwell <= 8'd0;
        end else begin
            r_prev  <= i_st;
            r_valid <= 1'b1;
            r_dwell <= w_dwell_nxt;
        end
    end

endmodule

// File: rtl/semaforo_monitor.sv
// Passive safety monitor for the two-light semaforo controller:
// prioritises tracker errors, keeps a sticky first error and counts A cycles.
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int T_VERDE    = 1,
    parameter int T_AMARELO  = 3,
    parameter int T_VERMELHO = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic       viol,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] a_cycles
);

    logic      w_a_enc, w_a_seq, w_a_dur, w_a_r2g, w_a_red;
    logic      w_b_enc, w_b_seq, w_b_dur, w_b_r2g, w_b_red;
    logic      w_conflict;
    err_code_t w_code;

    sem_phase_tracker #(
        .CHECK_DUR(1'b1),
        .T_G(T_VERDE),
        .T_Y(T_AMARELO),
        .T_R(T_VERMELHO)
    ) u_trk_a (
        .clk(clk),
        .rst(rst),
        .i_st(A),
        .o_enc_err(w_a_enc),
        .o_seq_err(w_a_seq),
        .o_dur_err(w_a_dur),
        .o_red_to_green(w_a_r2g),
        .o_is_red(w_a_red)
    );

    sem_phase_tracker #(
        .CHECK_DUR(1'b0),
        .T_G(T_VERDE),
        .T_Y(T_AMARELO),
        .T_R(T_VERMELHO)
    ) u_trk_b (
        .clk(clk),
        .rst(rst),
        .i_st(B),
        .o_enc_err(w_b_enc),
        .o_seq_err(w_b_seq),
        .o_dur_err(w_b_dur),
        .o_red_to_green(w_b_r2g),
        .o_is_red(w_b_red)
    );

    assign w_conflict = !w_a_red && !w_b_red;

    always_comb begin
        w_code = ERR_NONE;
        if (w_a_enc || w_b_enc)
            w_code = ERR_ENC;
        else if (w_conflict)
            w_code = ERR_CONFLICT;
        else if (w_a_seq || w_b_seq)
            w_code = ERR_SEQ;
        else if (w_a_dur)
            w_code = ERR_DUR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            viol     <= 1'b0;
            err      <= 1'b0;
            err_code <= 3'd0;
            a_cycles <= 8'd0;
        end else begin
            viol <= (w_code != ERR_NONE);
            if (!err && (w_code != ERR_NONE)) begin
                err      <= 1'b1;
                err_code <= w_code;
            end
            if (w_a_r2g && (a_cycles != 8'hFF))
                a_cycles <= a_cycles + 8'd1;
        end
    end

    logic w_unused;
    assign w_unused = w_b_dur ^ w_b_r2g;

endmodule
